// File: rtl/arith_pkg.sv
// Shared opcodes, flag bit positions and the result-FIFO entry layout
// for the arith_issue_capture stage.
package arith_pkg;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_MUL = 3'd2;
   localparam logic [2:0] OP_DIV = 3'd3;
   localparam logic [2:0] OP_MOD = 3'd4;

   localparam int FLG_ZERO = 0;
   localparam int FLG_OVF  = 1;
   localparam int FLG_DBZ  = 2;
   localparam int FLG_ILL  = 3;

   localparam int ENTRY_W = 3 + 4 + 4;

   typedef struct packed {
      logic [2:0] op;
      logic [3:0] res;
      logic [3:0] flags;
   } entry_t;

   function automatic logic is_legal(input logic [2:0] op);
      return op <= OP_MOD;
   endfunction

endpackage

// File: rtl/ArithOp.sv
// Existing combinational ArithOp unit: all five results of in1/in2, 4 bits each.
// Division and modulo by zero return 0.
module ArithOp (
   input  logic [3:0] in1,
   input  logic [3:0] in2,
   output logic [3:0] res1,
   output logic [3:0] res2,
   output logic [3:0] res3,
   output logic [3:0] res4,
   output logic [3:0] res5
);

   assign res1 = in1 + in2;
   assign res2 = in1 - in2;
   assign res3 = in1 * in2;
   assign res4 = (in2 == 4'd0) ? 4'd0 : in1 / in2;
   assign res5 = (in2 == 4'd0) ? 4'd0 : in1 % in2;

endmodule

// File: rtl/arith_res_fifo.sv
// Synchronous result FIFO, DEPTH entries of W bits, registered pointers and
// occupancy count. Push when full and pop when empty are ignored.
module arith_res_fifo
   import arith_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = ENTRY_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             wdata,
   input  logic                     pop,
   output logic [W-1:0]             rdata,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_push = push && (level != DEPTH_L);
   assign do_pop  = pop && (level != '0);
   assign rdata   = mem[rd_ptr];

   // Power-of-two depth lets the pointers wrap by natural overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + (AW+1)'(1);
            2'b01:   level <= level - (AW+1)'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/arith_issue_capture.sv
// Registers an operation request in front of ArithOp, selects the result,
// derives status flags and queues {op,res,flags} for a downstream consumer.
module arith_issue_capture
   import arith_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2:0]               in_op,
   input  logic [3:0]               in_a,
   input  logic [3:0]               in_b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [2:0]               out_op,
   output logic [3:0]               out_res,
   output logic [3:0]               out_flags,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int LW = $clog2(DEPTH) + 1;
   localparam logic [LW:0] DEPTH_L = (LW+1)'(DEPTH);

   logic          s1_v;
   logic [2:0]    s1_op;
   logic [3:0]    s1_a;
   logic [3:0]    s1_b;
   logic [3:0]    res1, res2, res3, res4, res5;
   logic [LW:0]   occ;
   entry_t        ent;
   entry_t        head;
   logic [ENTRY_W-1:0] head_bits;

   // Counting the S1 entry as occupied guarantees it always has a FIFO slot.
   assign occ      = {1'b0, level} + {{LW{1'b0}}, s1_v};
   assign in_ready = occ < DEPTH_L;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v  <= 1'b0;
         s1_op <= '0;
         s1_a  <= '0;
         s1_b  <= '0;
      end else begin
         s1_v <= in_valid && in_ready;
         if (in_valid && in_ready) begin
            s1_op <= in_op;
            s1_a  <= in_a;
            s1_b  <= in_b;
         end
      end
   end

   ArithOp u_arith (
      .in1  (s1_a),
      .in2  (s1_b),
      .res1 (res1),
      .res2 (res2),
      .res3 (res3),
      .res4 (res4),
      .res5 (res5)
   );

   // Overflow is judged on widened arithmetic, independent of ArithOp.
   always_comb begin
      ent       = '0;
      ent.op    = s1_op;
      case (s1_op)
         OP_ADD: begin
            ent.res            = res1;
            ent.flags[FLG_OVF] = ({1'b0, s1_a} + {1'b0, s1_b}) > 5'd15;
         end
         OP_SUB: begin
            ent.res            = res2;
            ent.flags[FLG_OVF] = s1_a < s1_b;
         end
         OP_MUL: begin
            ent.res            = res3;
            ent.flags[FLG_OVF] = ({4'b0, s1_a} * {4'b0, s1_b}) > 8'd15;
         end
         OP_DIV: begin
            ent.res            = (s1_b == 4'd0) ? 4'd0 : res4;
            ent.flags[FLG_DBZ] = s1_b == 4'd0;
         end
         OP_MOD: begin
            ent.res            = (s1_b == 4'd0) ? 4'd0 : res5;
            ent.flags[FLG_DBZ] = s1_b == 4'd0;
         end
         default: begin
            ent.res            = 4'd0;
            ent.flags[FLG_ILL] = !is_legal(s1_op);
         end
      endcase
      ent.flags[FLG_ZERO] = ent.res == 4'd0;
   end

   arith_res_fifo #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (s1_v),
      .wdata (ent),
      .pop   (out_valid && out_ready),
      .rdata (head_bits),
      .level (level)
   );

   assign head      = entry_t'(head_bits);
   assign out_valid = level != '0;
   assign out_op    = out_valid ? head.op    : '0;
   assign out_res   = out_valid ? head.res   : '0;
   assign out_flags = out_valid ? head.flags : '0;

endmodule

// File: tb/tb_arith_issue_capture.sv
// Directed bench for arith_issue_capture: a scoreboard queue is filled on
// accepted requests and drained by a monitor on every consumer pop.
module tb_arith_issue_capture;
   import arith_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_op;
   logic [3:0] in_a;
   logic [3:0] in_b;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] out_op;
   logic [3:0] out_res;
   logic [3:0] out_flags;
   logic [2:0] level;

   int n_checks = 0;
   int n_fail   = 0;
   entry_t q[$];

   always #5 clk = ~clk;

   arith_issue_capture #(.DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_op    (out_op),
      .out_res   (out_res),
      .out_flags (out_flags),
      .level     (level)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic entry_t model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      entry_t e;
      int r;
      e = '0;
      e.op = op;
      r = 0;
      case (op)
         3'd0: begin r = int'(a) + int'(b); e.flags[1] = r > 15; end
         3'd1: begin r = int'(a) - int'(b); e.flags[1] = r < 0; r = r + 16; end
         3'd2: begin r = int'(a) * int'(b); e.flags[1] = r > 15; end
         3'd3: begin if (b == 0) e.flags[2] = 1'b1; else r = int'(a) / int'(b); end
         3'd4: begin if (b == 0) e.flags[2] = 1'b1; else r = int'(a) % int'(b); end
         default: e.flags[3] = 1'b1;
      endcase
      e.res = 4'(r % 16);
      e.flags[0] = e.res == 4'd0;
      return e;
   endfunction

   // Scoreboard monitor: compares the head on every cycle the consumer takes it.
   always @(negedge clk) begin
      entry_t e;
      if (!rst && out_valid && out_ready) begin
         n_checks++;
         assert (q.size() != 0) else begin
            n_fail++;
            $error("FAIL sb_unexpected: observed op %0d res %0d, expected no output", out_op, out_res);
         end
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("sb_op", 32'(out_op), 32'(e.op));
            chk("sb_res", 32'(out_res), 32'(e.res));
            chk("sb_flags", 32'(out_flags), 32'(e.flags));
         end
      end
   end

   // Drives a request and holds it until accepted; waits counts the edges used.
   task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       output int waits);
      logic acc;
      in_valid = 1'b1;
      in_op = op;
      in_a = a;
      in_b = b;
      waits = 0;
      for (int i = 0; i < 20; i++) begin
         acc = in_ready;
         @(posedge clk); #1;
         waits++;
         if (acc) begin
            q.push_back(model(op, a, b));
            return;
         end
      end
      chk("send_timeout", 32'(waits), 32'd1);
   endtask

   task automatic drain(input string tag);
      out_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (q.size() == 0 && level == 3'd0) break;
      end
      chk({tag, "_sb_empty"}, 32'(q.size()), 32'd0);
      chk({tag, "_level"}, 32'(level), 32'd0);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      int w;
      int idx;
      logic acc;
      logic [2:0] fop [5];
      logic [3:0] fa  [5];
      logic [3:0] fb  [5];

      rst = 1'b1;
      in_valid = 1'b0;
      in_op = '0;
      in_a = '0;
      in_b = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_outs", 32'({out_op, out_res, out_flags}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      // Single add: latency of two edges from acceptance.
      out_ready = 1'b1;
      send(3'd0, 4'd5, 4'd3, w);
      in_valid = 1'b0;
      chk("lat_not_yet", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk("lat_valid", 32'(out_valid), 32'd1);
      chk("lat_res", 32'(out_res), 32'd8);
      chk("lat_flags", 32'(out_flags), 32'd0);
      chk("lat_op", 32'(out_op), 32'd0);
      @(posedge clk); #1;
      chk("lat_level", 32'(level), 32'd0);

      // Back-to-back requests, each must be taken on its first edge.
      send(3'd0, 4'd9, 4'd8, w); chk("b2b_w0", 32'(w), 32'd1);
      send(3'd1, 4'd3, 4'd5, w); chk("b2b_w1", 32'(w), 32'd1);
      send(3'd2, 4'd7, 4'd3, w); chk("b2b_w2", 32'(w), 32'd1);
      send(3'd2, 4'd0, 4'd6, w); chk("b2b_w3", 32'(w), 32'd1);
      in_valid = 1'b0;
      drain("b2b");

      // Divide/modulo by zero, normal div/mod, illegal opcode.
      send(3'd3, 4'd8, 4'd0, w);
      send(3'd4, 4'd8, 4'd0, w);
      send(3'd3, 4'd9, 4'd2, w);
      send(3'd4, 4'd9, 4'd2, w);
      send(3'd6, 4'd5, 4'd5, w);
      in_valid = 1'b0;
      drain("divill");

      // Backpressure: FIFO fills to DEPTH, one pop frees a slot for the 5th.
      out_ready = 1'b0;
      fop[0] = 3'd0; fa[0] = 4'd1;  fb[0] = 4'd1;
      fop[1] = 3'd1; fa[1] = 4'd7;  fb[1] = 4'd2;
      fop[2] = 3'd2; fa[2] = 4'd3;  fb[2] = 4'd3;
      fop[3] = 3'd0; fa[3] = 4'd15; fb[3] = 4'd1;
      fop[4] = 3'd3; fa[4] = 4'd15; fb[4] = 4'd4;
      idx = 0;
      in_valid = 1'b1;
      in_op = fop[0]; in_a = fa[0]; in_b = fb[0];
      for (int c = 0; c < 10; c++) begin
         acc = in_ready;
         @(posedge clk); #1;
         if (acc && idx < 5) begin
            q.push_back(model(fop[idx], fa[idx], fb[idx]));
            idx++;
            if (idx < 5) begin
               in_op = fop[idx]; in_a = fa[idx]; in_b = fb[idx];
            end
         end
      end
      chk("full_accepted", 32'(idx), 32'd4);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_level", 32'(level), 32'd4);
      out_ready = 1'b1;
      acc = in_ready;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("pop_level", 32'(level), 32'd3);
      chk("pop_in_ready", 32'(in_ready), 32'd1);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc && idx == 4) begin
         q.push_back(model(fop[4], fa[4], fb[4]));
         idx++;
      end
      chk("fifth_accepted", 32'(idx), 32'd5);
      in_valid = 1'b0;
      drain("full");

      // Reset with S1 valid and level 3 discards everything.
      out_ready = 1'b0;
      send(3'd0, 4'd2, 4'd2, w);
      send(3'd0, 4'd3, 4'd3, w);
      send(3'd0, 4'd4, 4'd4, w);
      send(3'd0, 4'd6, 4'd6, w);
      in_valid = 1'b0;
      chk("pre_rst_level", 32'(level), 32'd3);
      rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_level", 32'(level), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(3'd1, 4'd9, 4'd4, w);
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_res", 32'(out_res), 32'd5);
      chk("post_rst_flags", 32'(out_flags), 32'd0);
      drain("post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
